serv_bus_arbiter: RTL

Registered two-master Wishbone arbiter that shares the single external memory port, the one carried over the scan chain, between the SERV instruction bus and the data bus. It replaces the combinational cyc-priority mux with the following:
- an explicit grant state machine
- a selectable fairness policy
- a mandatory idle turnaround cycle after every transfer
- a timeout watchdog, so a missing ack from the slow scan-chain tester never deadlocks the core.

---
 rtl/serv_bus_pkg.sv | 17 +
 rtl/serv_bus_watchdog.sv | 26 ++
 rtl/serv_bus_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/serv_bus_pkg.sv
// Shared types and constants for the SERV instruction/data bus arbiter.
package serv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_I   = 2'd1,
    GNT_D   = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  // RV32I NOP (addi x0,x0,0), so a timed-out fetch executes harmlessly
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  localparam string POLICY_DBUS = "DBUS";
  localparam string POLICY_RR   = "RR";

endpackage

// File: rtl/serv_bus_watchdog.sv
// Grant-cycle counter for the arbiter; flags expiry one cycle before TIMEOUT is reached.
module serv_bus_watchdog #(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      cnt <= '0;
    else if (i_clr) cnt <= '0;
    else if (i_en)  cnt <= cnt + TIMEOUT_W'(1);
  end

  // TIMEOUT of 0 disables the watchdog entirely
  assign o_expired = (TIMEOUT != 0) && (cnt == LIMIT);

endmodule

// File: rtl/serv_bus_arbiter.sv
// Registered two-master Wishbone arbiter sharing the scan-chain memory port
// between the SERV instruction and data buses.
//
// state   | meaning
// IDLE    | no grant, shared port quiet, arbitrating pending requests
// GNT_I   | instruction bus owns the shared port
// GNT_D   | data bus owns the shared port
// RELEASE | one-cycle turnaround after ack/timeout while SERV drops cyc
module serv_bus_arbiter
  import serv_bus_pkg::*;
#(
  parameter string       PRIORITY  = POLICY_DBUS,
  parameter int          TIMEOUT   = 255,
  parameter int          TIMEOUT_W = 8,
  parameter logic [31:0] ERR_DATA  = RV_NOP
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  output logic [31:0] o_mem_adr,
  output logic [31:0] o_mem_dat,
  output logic [3:0]  o_mem_sel,
  output logic        o_mem_we,
  output logic        o_mem_cyc,
  input  logic [31:0] i_mem_rdt,
  input  logic        i_mem_ack,
  output logic        o_busy,
  output logic        o_timeout
);

  localparam bit RR_MODE = (PRIORITY == POLICY_RR);

  arb_state_e state, state_nxt;
  logic       last_d, last_d_nxt;
  logic       pick_d;
  logic       wd_clr, wd_en, wd_expired;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
    end
  end

  serv_bus_watchdog #(
    .TIMEOUT   (TIMEOUT),
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (wd_clr),
    .i_en      (wd_en),
    .o_expired (wd_expired)
  );

  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    pick_d     = 1'b0;
    wd_clr     = 1'b0;
    wd_en      = 1'b0;
    o_ibus_rdt = '0;
    o_ibus_ack = 1'b0;
    o_dbus_rdt = '0;
    o_dbus_ack = 1'b0;
    o_mem_adr  = '0;
    o_mem_dat  = '0;
    o_mem_sel  = '0;
    o_mem_we   = 1'b0;
    o_mem_cyc  = 1'b0;
    o_timeout  = 1'b0;

    case (state)
      IDLE: begin
        // Tie: fixed dbus priority, or round-robin away from the last winner
        if (i_dbus_cyc && i_ibus_cyc) pick_d = RR_MODE ? !last_d : 1'b1;
        else                          pick_d = i_dbus_cyc;
        if (i_dbus_cyc || i_ibus_cyc) begin
          state_nxt  = pick_d ? GNT_D : GNT_I;
          last_d_nxt = pick_d;
          wd_clr     = 1'b1;
        end
      end
      GNT_I: begin
        o_mem_cyc = 1'b1;
        o_mem_adr = i_ibus_adr;
        o_mem_sel = 4'hF;
        if (i_mem_ack) begin
          o_ibus_ack = 1'b1;
          o_ibus_rdt = i_mem_rdt;
          state_nxt  = RELEASE;
        end else if (!i_ibus_cyc) begin
          state_nxt = IDLE;
        end else begin
          wd_en = 1'b1;
          if (wd_expired) begin
            o_ibus_ack = 1'b1;
            o_ibus_rdt = ERR_DATA;
            o_timeout  = 1'b1;
            state_nxt  = RELEASE;
          end
        end
      end
      GNT_D: begin
        o_mem_cyc = 1'b1;
        o_mem_adr = i_dbus_adr;
        o_mem_dat = i_dbus_dat;
        o_mem_sel = i_dbus_sel;
        o_mem_we  = i_dbus_we;
        if (i_mem_ack) begin
          o_dbus_ack = 1'b1;
          o_dbus_rdt = i_mem_rdt;
          state_nxt  = RELEASE;
        end else if (!i_dbus_cyc) begin
          state_nxt = IDLE;
        end else begin
          wd_en = 1'b1;
          if (wd_expired) begin
            o_dbus_ack = 1'b1;
            o_dbus_rdt = ERR_DATA;
            o_timeout  = 1'b1;
            state_nxt  = RELEASE;
          end
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);

endmodule
